// File: rtl/riscv_bp_track_pkg.sv
// Shared branch-predictor tracking types and default widths.
package riscv_bp_track_pkg;

    localparam int unsigned RV_XLEN   = 32;
    localparam int unsigned BP_HIST_W = 2;
    localparam int unsigned BP_PRED_W = 2;

    // One in-flight branch: its PC, the counter read at prediction time and
    // the speculative history used to index the predictor for it.
    typedef struct packed {
        logic [RV_XLEN-1:0]   pc;
        logic [BP_PRED_W-1:0] predict;
        logic [BP_HIST_W-1:0] history;
    } bp_entry_t;

endpackage

// File: rtl/riscv_bp_fifo.sv
// In-flight branch queue: power-of-two depth, push/pop/clear, full/empty.
module riscv_bp_fifo #(
    parameter int unsigned W     = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Full/empty decoded straight from the occupancy register
    always_comb begin
        full_o  = (count_q == CW'(DEPTH));
        empty_o = (count_q == '0);
        do_pop  = pop_i && !empty_o && !clear_i;
        do_push = push_i && (!full_o || pop_i) && !clear_i;
        rdata_o = mem[rd_ptr_q];
    end

    // Pointer and occupancy update; clear overrides any push/pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/riscv_bp_track.sv
// Tracks in-flight branches between ID and EX, maintains speculative and
// committed global history, and produces the predictor update.
module riscv_bp_track
    import riscv_bp_track_pkg::*;
#(
    parameter int unsigned XLEN           = RV_XLEN,
    parameter int unsigned BP_GLOBAL_BITS = BP_HIST_W,
    parameter int unsigned DEPTH          = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_push_i,
    input  logic [XLEN-1:0]           id_pc_i,
    input  logic [1:0]                bp_predict_i,
    input  logic                      ex_resolve_i,
    input  logic                      ex_btaken_i,
    input  logic                      flush_i,
    output logic [BP_GLOBAL_BITS-1:0] rd_history_o,
    output logic [BP_GLOBAL_BITS-1:0] bu_bp_history_o,
    output logic [1:0]                bu_bp_predict_o,
    output logic                      bu_bp_btaken_o,
    output logic                      bu_bp_update_o,
    output logic [XLEN-1:0]           ex_pc_o,
    output logic                      mispredict_o,
    output logic                      full_o,
    output logic                      empty_o
);

    typedef struct packed {
        logic [XLEN-1:0]           pc;
        logic [BP_PRED_W-1:0]      predict;
        logic [BP_GLOBAL_BITS-1:0] history;
    } entry_t;

    localparam int unsigned EW = $bits(entry_t);

    logic [BP_GLOBAL_BITS-1:0] spec_hist_q, spec_hist_d;
    logic [BP_GLOBAL_BITS-1:0] comm_hist_q, comm_hist_d;
    entry_t                    push_entry;
    entry_t                    head;
    logic                      pop;
    logic                      mispred;
    logic                      push_ok;
    logic                      fifo_clear;
    logic                      fifo_full;
    logic                      fifo_empty;

    riscv_bp_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_ok),
        .pop_i   (pop),
        .clear_i (fifo_clear),
        .wdata_i (push_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Resolve/mispredict decode and next-state for both history registers.
    // A mispredict clears the queue, which also drops the popped head and any
    // same-cycle push; speculative history then restarts from the new commit.
    always_comb begin
        pop         = ex_resolve_i && !fifo_empty;
        mispred     = pop && (head.predict[1] != ex_btaken_i);
        fifo_clear  = flush_i || mispred;
        push_ok     = id_push_i && !fifo_clear && (!fifo_full || pop);
        push_entry  = '{pc: id_pc_i, predict: bp_predict_i, history: spec_hist_q};

        comm_hist_d = comm_hist_q;
        if (pop) comm_hist_d = (comm_hist_q << 1) | BP_GLOBAL_BITS'(ex_btaken_i);

        spec_hist_d = spec_hist_q;
        if (fifo_clear)   spec_hist_d = comm_hist_d;
        else if (push_ok) spec_hist_d = (spec_hist_q << 1) | BP_GLOBAL_BITS'(bp_predict_i[1]);
    end

    // History registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spec_hist_q <= '0;
            comm_hist_q <= '0;
        end else begin
            spec_hist_q <= spec_hist_d;
            comm_hist_q <= comm_hist_d;
        end
    end

    // Registered predictor update, one cycle after the pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bu_bp_update_o  <= 1'b0;
            mispredict_o    <= 1'b0;
            bu_bp_btaken_o  <= 1'b0;
            bu_bp_predict_o <= '0;
            bu_bp_history_o <= '0;
            ex_pc_o         <= '0;
        end else begin
            bu_bp_update_o <= pop;
            mispredict_o   <= mispred;
            if (pop) begin
                bu_bp_btaken_o  <= ex_btaken_i;
                bu_bp_predict_o <= head.predict;
                bu_bp_history_o <= head.history;
                ex_pc_o         <= head.pc;
            end
        end
    end

    assign rd_history_o = spec_hist_q;
    assign full_o       = fifo_full;
    assign empty_o      = fifo_empty;

endmodule
